// File: rtl/sensor_acquisition.sv
// Scans NR_SENSORS sensors in turn over a shared req/ack bus, building a frame in shadow registers.
// A finished frame is copied to the outputs in one edge, with a one-cycle frame_valid_o strobe.
module sensor_acquisition #(
   parameter int NR_SENSORS  = 5,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 16,
   parameter int AUTO_PERIOD = 0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   output logic [2:0]                   sensor_sel_o,
   output logic                         sensor_req_o,
   input  logic                         sensor_ack_i,
   input  logic [DATA_W-1:0]            sensor_data_i,
   output logic [NR_SENSORS*DATA_W-1:0] sensors_data_o,
   output logic [NR_SENSORS-1:0]        sensors_en_o,
   output logic                         frame_valid_o,
   output logic                         busy_o
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [2:0]    LAST_SEL      = 3'(NR_SENSORS - 1);
   localparam logic [TW-1:0] TMO_LAST      = TW'(TIMEOUT_CYC - 1);
   localparam logic [PW-1:0] PERIOD_RELOAD = (AUTO_PERIOD > 0) ? PW'(AUTO_PERIOD - 1) : '0;

   typedef enum logic [1:0] {IDLE, WAIT, GAP, PUBLISH} state_t;

   state_t                       state, state_nxt;
   logic [NR_SENSORS*DATA_W-1:0] shadow_data;
   logic [NR_SENSORS-1:0]        shadow_en;
   logic [TW-1:0]                tmo_cnt;
   logic [PW-1:0]                period_cnt;
   logic                         pending;
   logic                         launch;
   logic                         timed_out;
   logic                         period_hit;

   assign launch     = (state == IDLE) && (start_i || pending);
   assign timed_out  = (state == WAIT) && !sensor_ack_i && (tmo_cnt == TMO_LAST);
   assign period_hit = (AUTO_PERIOD > 0) && (period_cnt == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      sensor_req_o = 1'b0;
      busy_o       = 1'b0;
      case (state)
         IDLE: begin
            if (launch) state_nxt = WAIT;
         end
         WAIT: begin
            sensor_req_o = 1'b1;
            busy_o       = 1'b1;
            if (sensor_ack_i || timed_out)
               state_nxt = (sensor_sel_o == LAST_SEL) ? PUBLISH : GAP;
         end
         GAP: begin
            busy_o    = 1'b1;
            state_nxt = WAIT;
         end
         PUBLISH: begin
            busy_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sensor_sel_o   <= '0;
         sensors_data_o <= '0;
         sensors_en_o   <= '0;
         frame_valid_o  <= 1'b0;
         shadow_data    <= '0;
         shadow_en      <= '0;
         tmo_cnt        <= '0;
         period_cnt     <= '0;
         pending        <= 1'b0;
      end else begin
         frame_valid_o <= 1'b0;
         if (AUTO_PERIOD > 0)
            period_cnt <= period_hit ? PERIOD_RELOAD : period_cnt - PW'(1);
         // A trigger landing on the launch edge must survive for the next scan.
         if (period_hit)  pending <= 1'b1;
         else if (launch) pending <= 1'b0;

         case (state)
            IDLE: begin
               if (launch) begin
                  sensor_sel_o <= '0;
                  shadow_data  <= '0;
                  shadow_en    <= '0;
                  tmo_cnt      <= '0;
               end
            end
            WAIT: begin
               if (sensor_ack_i) begin
                  for (int k = 0; k < NR_SENSORS; k++) begin
                     if (sensor_sel_o == 3'(k)) begin
                        shadow_data[k*DATA_W +: DATA_W] <= sensor_data_i;
                        shadow_en[k]                    <= 1'b1;
                     end
                  end
               end else if (timed_out) begin
                  for (int k = 0; k < NR_SENSORS; k++) begin
                     if (sensor_sel_o == 3'(k)) begin
                        shadow_data[k*DATA_W +: DATA_W] <= '0;
                        shadow_en[k]                    <= 1'b0;
                     end
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            GAP: begin
               sensor_sel_o <= sensor_sel_o + 3'd1;
               tmo_cnt      <= '0;
            end
            PUBLISH: begin
               sensors_data_o <= shadow_data;
               sensors_en_o   <= shadow_en;
               frame_valid_o  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_acquisition.sv
// Directed bench for sensor_acquisition: table of sensor response patterns plus hand-written
// sequences for reset mid-scan, start handling and auto-trigger.
module tb_sensor_acquisition;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  sel;
   logic        req;
   logic        ack;
   logic [7:0]  data;
   logic [39:0] sensors_data;
   logic [4:0]  sensors_en;
   logic        frame_valid;
   logic        busy;

   logic        rst_a = 1'b1;
   logic [2:0]  sel_a;
   logic        req_a;
   logic [39:0] sensors_data_a;
   logic [4:0]  sensors_en_a;
   logic        frame_valid_a;
   logic        busy_a;

   logic             use_ovr = 1'b1;
   logic             ack_ovr = 1'b0;
   logic [7:0]       data_ovr = 8'h00;
   logic [4:0][7:0]  rsp_data = '0;
   logic [4:0][4:0]  rsp_dly = '0;
   logic [7:0]       wcnt = 8'd0;
   logic [4:0]       cur_dly;
   logic             model_ack;

   int tests = 0;
   int failed = 0;
   int cyc = 0;
   logic [39:0] prev_data = '0;
   logic [4:0]  prev_en = '0;

   typedef struct {
      logic [39:0]     data;
      logic [4:0][4:0] dly;   // WAIT cycle in which each sensor acks, 0 = never
      logic [4:0]      exp_en;
      logic [39:0]     exp_data;
      int              exp_lat;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) wcnt <= req ? wcnt + 8'd1 : 8'd0;

   assign cur_dly   = rsp_dly[sel];
   assign model_ack = req && (cur_dly != 5'd0) && ({3'b000, cur_dly} == wcnt + 8'd1);
   assign ack       = use_ovr ? ack_ovr : model_ack;
   assign data      = use_ovr ? data_ovr : rsp_data[sel];

   sensor_acquisition #(.NR_SENSORS(5), .DATA_W(8), .TIMEOUT_CYC(16), .AUTO_PERIOD(0)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .sensor_sel_o(sel), .sensor_req_o(req), .sensor_ack_i(ack), .sensor_data_i(data),
      .sensors_data_o(sensors_data), .sensors_en_o(sensors_en),
      .frame_valid_o(frame_valid), .busy_o(busy)
   );

   sensor_acquisition #(.NR_SENSORS(5), .DATA_W(8), .TIMEOUT_CYC(16), .AUTO_PERIOD(8)) dut_a (
      .clk_i(clk), .rst_i(rst_a), .start_i(1'b0),
      .sensor_sel_o(sel_a), .sensor_req_o(req_a), .sensor_ack_i(req_a),
      .sensor_data_i(8'h40 + {5'd0, sel_a}),
      .sensors_data_o(sensors_data_a), .sensors_en_o(sensors_en_a),
      .frame_valid_o(frame_valid_a), .busy_o(busy_a)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int idx);
      int n;
      bit held;
      rsp_data = tbl[idx].data;
      rsp_dly  = tbl[idx].dly;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      held = 1'b1;
      while (!frame_valid && n < 200) begin
         if (sensors_data !== prev_data || sensors_en !== prev_en) held = 1'b0;
         step();
         n++;
      end
      check($sformatf("v%0d_held", idx), 64'(held), 64'd1);
      check($sformatf("v%0d_latency", idx), 64'(n), 64'(tbl[idx].exp_lat));
      check($sformatf("v%0d_en", idx), 64'(sensors_en), 64'(tbl[idx].exp_en));
      check($sformatf("v%0d_data", idx), 64'(sensors_data), 64'(tbl[idx].exp_data));
      step();
      check($sformatf("v%0d_strobe_width", idx), 64'(frame_valid), 64'd0);
      prev_data = tbl[idx].exp_data;
      prev_en   = tbl[idx].exp_en;
   endtask

   initial begin
      int n, frames;
      int ft [5];

      tbl[0] = '{40'h13_12_15_19_14, {5'd1, 5'd1, 5'd1, 5'd1, 5'd1}, 5'b11111, 40'h13_12_15_19_14, 10};
      tbl[1] = '{40'h13_12_15_19_14, {5'd1, 5'd1, 5'd1, 5'd0, 5'd1}, 5'b11101, 40'h13_12_15_00_14, 25};
      tbl[2] = '{40'h13_12_15_19_14, {5'd1, 5'd1, 5'd16, 5'd1, 5'd1}, 5'b11111, 40'h13_12_15_19_14, 25};
      tbl[3] = '{40'h13_12_15_19_14, {5'd1, 5'd1, 5'd17, 5'd1, 5'd1}, 5'b11011, 40'h13_12_00_19_14, 25};
      tbl[4] = '{40'hEE_DD_CC_BB_AA, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0}, 5'b00000, 40'h00_00_00_00_00, 85};
      tbl[5] = '{40'hEE_DD_CC_BB_AA, {5'd1, 5'd5, 5'd1, 5'd1, 5'd3}, 5'b11111, 40'hEE_DD_CC_BB_AA, 16};

      // Reset with inputs toggling
      for (int i = 0; i < 6; i++) begin
         start    = i[0];
         ack_ovr  = ~i[0];
         data_ovr = 8'($urandom);
         step();
      end
      check("rst_data", 64'(sensors_data), 64'd0);
      check("rst_en", 64'(sensors_en), 64'd0);
      check("rst_valid", 64'(frame_valid), 64'd0);
      check("rst_req", 64'(req), 64'd0);
      check("rst_sel", 64'(sel), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_busy_auto", 64'(busy_a), 64'd0);
      start   = 1'b0;
      ack_ovr = 1'b1;
      rst     = 1'b0;
      step();
      step();
      step();
      check("idle_ack_ignored", 64'({busy, frame_valid}), 64'd0);
      ack_ovr = 1'b0;
      use_ovr = 1'b0;

      for (int i = 0; i < 6; i++) run_frame(i);

      // Reset while sensor 3 is waiting
      rsp_data = tbl[0].data;
      rsp_dly  = {5'd1, 5'd0, 5'd1, 5'd1, 5'd1};
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!(req && sel == 3'd3) && n < 100) begin
         step();
         n++;
      end
      check("mid_reset_reached_s3", 64'(req && sel == 3'd3), 64'd1);
      rst = 1'b1;
      step();
      check("mid_reset_req", 64'(req), 64'd0);
      check("mid_reset_outputs", 64'({sensors_data, sensors_en, frame_valid, busy}), 64'd0);
      rst = 1'b0;
      frames = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (frame_valid) frames++;
      end
      check("mid_reset_no_frame", 64'(frames), 64'd0);
      prev_data = '0;
      prev_en   = '0;
      run_frame(0);

      // A start pulse during a scan is dropped
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      start = 1'b1;
      step();
      start = 1'b0;
      frames = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (frame_valid) frames++;
      end
      check("start_during_scan_frames", 64'(frames), 64'd1);

      // start held high: back-to-back frames
      frames = 0;
      n = 0;
      start = 1'b1;
      while (frames < 3 && n < 200) begin
         step();
         n++;
         if (frame_valid) begin
            ft[frames] = cyc;
            frames++;
         end
      end
      start = 1'b0;
      check("held_frames", 64'(frames), 64'd3);
      check("held_spacing_1", 64'(ft[1] - ft[0]), 64'd11);
      check("held_spacing_2", 64'(ft[2] - ft[1]), 64'd11);
      step();
      check("held_release_idle", 64'(busy), 64'd0);

      // Auto-trigger every 8 cycles, scans of 10 edges
      rst_a = 1'b0;
      frames = 0;
      n = 0;
      while (frames < 5 && n < 300) begin
         step();
         n++;
         if (frame_valid_a) begin
            ft[frames] = cyc;
            frames++;
         end
      end
      check("auto_frames", 64'(frames), 64'd5);
      for (int i = 1; i < 5; i++)
         check($sformatf("auto_spacing_%0d", i), 64'(ft[i] - ft[i-1]), 64'd11);
      check("auto_en", 64'(sensors_en_a), 64'h1f);
      check("auto_data", 64'(sensors_data_a), 64'h44_43_42_41_40);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/sensor_acquisition.md
Name: sensor_acquisition

Overview:
- Upstream stage of temperature_top. Scans the NR_SENSORS temperature sensors one at a time over a shared request/acknowledge bus.
- Packs the readings into the sensors_data/sensors_en frame format that temperature_top consumes.
- Marks sensors that fail to answer within a timeout as inactive.
- Publishes each complete frame atomically, with a one-cycle frame_valid_o strobe.

Parameters:
- NR_SENSORS, 5, number of sensors scanned per frame.
- DATA_W, 8, width of one sensor reading.
- TIMEOUT_CYC, 16, maximum number of WAIT cycles per sensor before it is declared inactive (≥1).
- AUTO_PERIOD, 0, auto-trigger period in cycles. 0 disables auto-trigger, so only start_i launches a scan.

Ports:
- clk_i, in, 1, clock. All logic is on the rising edge.
- rst_i, in, 1, reset; synchronous and active-high.
- start_i, in, 1, scan request, sampled in IDLE only.
- sensor_sel_o, out, 3, index of the sensor being addressed.
- sensor_req_o, out, 1, read request to the addressed sensor.
- sensor_ack_i, in, 1, sensor acknowledge; data is valid when this is high.
- sensor_data_i, in, DATA_W, reading from the addressed sensor.
- sensors_data_o, out, NR_SENSORS*DATA_W, packed frame to temperature_top.sensors_data_i.
- sensors_en_o, out, NR_SENSORS, active mask to temperature_top.sensors_en_i.
- frame_valid_o, out, 1, one-cycle strobe marking a new frame.
- busy_o, out, 1, high while a scan is in progress.

Behaviour:
- Reset: all of the following are 0 on the first edge with rst_i=1: sensors_data_o, sensors_en_o, frame_valid_o, sensor_req_o, sensor_sel_o, busy_o, internal shadow registers, timeout counter, period counter, pending flag. State becomes IDLE.
- Reset mid-scan aborts the scan and drops sensor_req_o at the same edge. No partial frame is ever published.
- Packing: sensor k occupies sensors_data_o[8k+7:8k] and sensors_en_o[k]. Sensor 0 is the LSB.
- FSM states are IDLE, WAIT, GAP, PUBLISH.
- IDLE:
  - req=0, busy=0.
  - On start_i=1 or pending=1: sel←0, clear shadow data and shadow mask, clear pending, go to WAIT.
- WAIT:
  - req=1, busy=1, sel stable.
  - sensor_ack_i is sampled every cycle. On ack: shadow[sel]←sensor_data_i, shadow_en[sel]←1.
  - If no ack arrives within TIMEOUT_CYC cycles: shadow[sel]←0, shadow_en[sel]←0.
  - Ack in the TIMEOUT_CYC-th cycle counts as a valid response.
  - Next state is GAP, or PUBLISH if sel=NR_SENSORS-1.
- GAP:
  - Exactly 1 cycle with req=0 and busy=1.
  - sel increments, timeout counter clears, then go to WAIT.
- PUBLISH:
  - 1 cycle with req=0 and busy=1.
  - On the edge leaving this state, sensors_data_o and sensors_en_o load from the shadow registers and frame_valid_o←1. State becomes IDLE.
- frame_valid_o is high for exactly one cycle.
- Outputs hold the previous frame for the whole duration of a scan.
- sensor_ack_i is ignored while sensor_req_o=0.
- start_i is ignored while busy, except through the pending flag for auto-trigger; a start_i pulse during a scan is dropped.
- A start accepted in the frame_valid_o cycle (IDLE) is legal, giving back-to-back frames.
- Auto-trigger (AUTO_PERIOD>0):
  - A free-running down-counter reloads AUTO_PERIOD-1 on reaching 0 and sets pending at that point.
  - If pending is set during a scan, it launches the next scan immediately after PUBLISH.
  - start_i and pending together launch one scan only.
- Latency: if every sensor acks in its first WAIT cycle, frame_valid_o rises 2*NR_SENSORS edges after the start_i sampling edge (10 for the defaults). Each timed-out sensor adds TIMEOUT_CYC-1 edges.
- Width rule: the timeout counter is wide enough for TIMEOUT_CYC and never wraps.

Test Plan:
- Reset with every input toggling: all outputs 0. Then start_i with sensor_ack_i tied to sensor_req_o → no output change before frame_valid_o, which rises exactly 10 edges after start.
- Readings s0..s4 = 0x14,0x19,0x15,0x12,0x13, with s1 never acking → sensors_en_o=5'b11101 and sensors_data_o=40'h13_12_15_00_14. frame_valid_o is delayed by 15 extra edges.
- Sensor 2 acks in WAIT cycle 16 (the last one) → en[2]=1 and its data captured. A separate run with the ack in cycle 17 → en[2]=0 and data byte 0x00.
- Reset asserted while sel=3 in WAIT → req=0 at that edge. No frame_valid_o. Outputs zero. A fresh start afterwards yields a correct full frame.
- start_i pulsed during a scan → ignored (one frame only). start_i held high continuously → back-to-back frames spaced 11 edges apart.
- AUTO_PERIOD=8 with 10-edge scans → each next scan starts right after PUBLISH, and no trigger is lost or duplicated over 5 frames.
